// File: rtl/face_roi_ctrl.sv
// rtl/face_roi_ctrl.sv - per-frame face box check and eye-search ROI publisher
// Optional FACE_ROI_SMOOTH_EN: average each new window with the held one.
module face_roi_ctrl #(
  parameter logic [11:0] MIN_W  = 12'd120,
  parameter logic [11:0] MIN_H  = 12'd150,
  parameter logic [2:0]  LOST_N = 3'd4
) (
  input  logic        module_clk,
  input  logic        module_rst_n,
  input  logic        cam_vsync,
  input  logic [11:0] face_left,
  input  logic [11:0] face_right,
  input  logic [11:0] face_up,
  input  logic [11:0] face_down,
  input  logic        roi_ready,
  output logic        roi_valid,
  output logic [11:0] roi_x0,
  output logic [11:0] roi_x1,
  output logic [11:0] roi_y0,
  output logic [11:0] roi_y1,
  output logic        face_lost
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    CHECK   = 3'd2,
    UPDATE  = 3'd3,
    PUBLISH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        vs_r0_q, vs_r1_q;
  logic        pend_q, pend_d;
  logic [11:0] left_q, right_q, up_q, down_q;
  logic [2:0]  lost_cnt_q, lost_cnt_d;
  logic        face_lost_q, face_lost_d;
  logic [11:0] x0_q, x1_q, y0_q, y1_q;
  logic [11:0] x0_d, x1_d, y0_d, y1_d;
  logic        vs_edge;
  logic [11:0] box_w, box_h, new_y0, new_y1;
  logic        frame_ok;
`ifdef FACE_ROI_SMOOTH_EN
  logic        have_roi_q, have_roi_d;

  function automatic logic [11:0] avg12(input logic [11:0] a, input logic [11:0] b);
    return 12'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction
`endif

  assign vs_edge  = vs_r0_q & ~vs_r1_q;
  assign box_w    = right_q - left_q;
  assign box_h    = down_q - up_q;
  assign new_y0   = up_q + (box_h >> 2);
  assign new_y1   = up_q + (box_h >> 1);
  assign frame_ok = (right_q > left_q) && (down_q > up_q) &&
                    (box_w >= MIN_W) && (box_h >= MIN_H) &&
                    (right_q <= 12'd639) && (down_q <= 12'd479);

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      state_q     <= IDLE;
      vs_r0_q     <= 1'b0;
      vs_r1_q     <= 1'b0;
      pend_q      <= 1'b0;
      left_q      <= 12'd0;
      right_q     <= 12'd0;
      up_q        <= 12'd0;
      down_q      <= 12'd0;
      lost_cnt_q  <= 3'd0;
      face_lost_q <= 1'b0;
      x0_q        <= 12'd0;
      x1_q        <= 12'd0;
      y0_q        <= 12'd0;
      y1_q        <= 12'd0;
`ifdef FACE_ROI_SMOOTH_EN
      have_roi_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      vs_r0_q     <= cam_vsync;
      vs_r1_q     <= vs_r0_q;
      pend_q      <= pend_d;
      lost_cnt_q  <= lost_cnt_d;
      face_lost_q <= face_lost_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
`ifdef FACE_ROI_SMOOTH_EN
      have_roi_q  <= have_roi_d;
`endif
      // The face box is only captured here; it is ignored at every other time.
      if (state_q == SAMPLE) begin
        left_q  <= face_left;
        right_q <= face_right;
        up_q    <= face_up;
        down_q  <= face_down;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    lost_cnt_d = lost_cnt_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
`ifdef FACE_ROI_SMOOTH_EN
    have_roi_d = have_roi_q;
`endif
    case (state_q)
      IDLE: begin
        if (vs_edge || pend_q) begin
          state_d = SAMPLE;
          pend_d  = 1'b0;
        end
      end
      SAMPLE: state_d = CHECK;
      CHECK: begin
        if (frame_ok) begin
          state_d = UPDATE;
        end else begin
          state_d = IDLE;
          if (lost_cnt_q != LOST_N) lost_cnt_d = lost_cnt_q + 3'd1;
        end
      end
      UPDATE: begin
        state_d    = PUBLISH;
        lost_cnt_d = 3'd0;
`ifdef FACE_ROI_SMOOTH_EN
        have_roi_d = 1'b1;
        // A fresh track (after reset or a lost face) must not be blended with stale data.
        if (!have_roi_q || face_lost_q) begin
          x0_d = left_q;
          x1_d = right_q;
          y0_d = new_y0;
          y1_d = new_y1;
        end else begin
          x0_d = avg12(x0_q, left_q);
          x1_d = avg12(x1_q, right_q);
          y0_d = avg12(y0_q, new_y0);
          y1_d = avg12(y1_q, new_y1);
        end
`else
        x0_d = left_q;
        x1_d = right_q;
        y0_d = new_y0;
        y1_d = new_y1;
`endif
      end
      PUBLISH: begin
        if (roi_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Edges arriving while busy collapse into a single pending request.
    if (state_q != IDLE && vs_edge) pend_d = 1'b1;
    face_lost_d = (lost_cnt_d == LOST_N);
  end

  assign roi_valid = (state_q == PUBLISH);
  assign roi_x0    = x0_q;
  assign roi_x1    = x1_q;
  assign roi_y0    = y0_q;
  assign roi_y1    = y1_q;
  assign face_lost = face_lost_q;

endmodule

// File: tb/tb_face_roi_ctrl.sv
// tb/tb_face_roi_ctrl.sv - directed self-checking bench for face_roi_ctrl
module tb_face_roi_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic [11:0] f_left, f_right, f_up, f_down;
  logic        ready;
  logic        valid;
  logic [11:0] x0, x1, y0, y1;
  logic        lost;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  face_roi_ctrl dut (
    .module_clk  (clk),
    .module_rst_n(rst_n),
    .cam_vsync   (vsync),
    .face_left   (f_left),
    .face_right  (f_right),
    .face_up     (f_up),
    .face_down   (f_down),
    .roi_ready   (ready),
    .roi_valid   (valid),
    .roi_x0      (x0),
    .roi_x1      (x1),
    .roi_y0      (y0),
    .roi_y1      (y1),
    .face_lost   (lost)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_box(input logic [11:0] l, input logic [11:0] r,
                         input logic [11:0] u, input logic [11:0] d);
    f_left = l; f_right = r; f_up = u; f_down = d;
  endtask

  task automatic vsync_pulse();
    @(negedge clk) vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_roi(input string tag, input logic [11:0] ex0, input logic [11:0] ex1,
                         input logic [11:0] ey0, input logic [11:0] ey1);
    chk({tag, "_x0"}, x0, ex0);
    chk({tag, "_x1"}, x1, ex1);
    chk({tag, "_y0"}, y0, ey0);
    chk({tag, "_y1"}, y1, ey1);
  endtask

  initial begin
    int seen;
    logic prev;
    rst_n = 1'b0; vsync = 1'b0; ready = 1'b1;
    set_box(12'd0, 12'd0, 12'd0, 12'd0);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_lost", lost, 0);
    chk_roi("rst", 12'd0, 12'd0, 12'd0, 12'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Box A: h=347 -> y0=100+86, y1=100+173; valid exactly one cycle after edge k+4
    set_box(12'd200, 12'd440, 12'd100, 12'd447);
    ready = 1'b1;
    @(negedge clk) vsync = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_valid_e%0d", i), valid, (i == 4) ? 1 : 0);
      if (i == 2) vsync = 1'b0;
      if (i == 4) begin
        chk_roi("lat", 12'd200, 12'd440, 12'd186, 12'd273);
        chk("lat_lost", lost, 0);
      end
    end
    repeat (2) @(negedge clk);

    // Stall: ready low 10 cycles, then handshake on the 11th
    ready = 1'b0;
    vsync_pulse();
    wait_valid("stall_rise");
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid && x0 == 12'd200 && x1 == 12'd440 && y0 == 12'd186 && y1 == 12'd273) seen++;
      @(posedge clk); #1;
    end
    chk("stall_held10", seen, 10);
    ready = 1'b1;
    chk("stall_cycle11", valid, 1);
    @(posedge clk); #1;
    chk("stall_drop", valid, 0);
    repeat (3) @(negedge clk);

    // Four too-narrow frames (R-L=50) -> no publish, lost after the 4th
    set_box(12'd200, 12'd250, 12'd100, 12'd447);
    for (int f = 1; f <= 4; f++) begin
      seen = 0;
      vsync_pulse();
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (valid) seen++;
      end
      chk($sformatf("inv_novalid_f%0d", f), seen, 0);
      chk($sformatf("inv_lost_f%0d", f), lost, (f == 4) ? 1 : 0);
    end
    chk_roi("inv_held", 12'd200, 12'd440, 12'd186, 12'd273);

    // Box B: w=200, h=200 -> y0=100, y1=150; clears face_lost
    set_box(12'd100, 12'd300, 12'd50, 12'd250);
    vsync_pulse();
    wait_valid("recover_rise");
    chk("recover_lost", lost, 0);
    chk_roi("recover", 12'd100, 12'd300, 12'd100, 12'd150);
    repeat (3) @(negedge clk);

    // Two vsync edges during a stalled publish -> exactly one more publish
    ready = 1'b0;
    vsync_pulse();
    wait_valid("pend_rise");
    vsync_pulse();
    vsync_pulse();
    chk("pend_still_valid", valid, 1);
    @(negedge clk) ready = 1'b1;
    @(posedge clk); #1;
    chk("pend_drop", valid, 0);
    seen = 0;
    prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (valid && !prev) seen++;
      prev = valid;
    end
    chk("pend_publishes", seen, 1);
    chk_roi("pend", 12'd100, 12'd300, 12'd100, 12'd150);

    // Smoothing: L=200 then L=300
    do_reset();
    ready = 1'b1;
    set_box(12'd200, 12'd440, 12'd100, 12'd447);
    vsync_pulse();
    wait_valid("smooth1_rise");
    chk("smooth1_x0", x0, 200);
    repeat (3) @(negedge clk);
    set_box(12'd300, 12'd440, 12'd100, 12'd447);
    vsync_pulse();
    wait_valid("smooth2_rise");
`ifdef FACE_ROI_SMOOTH_EN
    chk("smooth2_x0", x0, 250);
`else
    chk("smooth2_x0", x0, 300);
`endif
    chk("smooth2_x1", x1, 440);
    repeat (3) @(negedge clk);

    // Reset asserted mid-publish clears outputs without a clock edge
    do_reset();
    ready = 1'b0;
    set_box(12'd200, 12'd440, 12'd100, 12'd447);
    vsync_pulse();
    wait_valid("arst_rise");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_lost", lost, 0);
    chk_roi("arst", 12'd0, 12'd0, 12'd0, 12'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_idle", valid, 0);
    ready = 1'b1;
    vsync_pulse();
    wait_valid("arst_restart");
    chk_roi("arst_restart", 12'd200, 12'd440, 12'd186, 12'd273);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/face_roi_ctrl.md
FACE_ROI_CTRL -- requirements
Module: face_roi_ctrl

Interface
REQ-001 SHALL have parameter MIN_W, default 12'd120: minimum accepted face width in pixels.
REQ-002 SHALL have parameter MIN_H, default 12'd150: minimum accepted face height in lines.
REQ-003 SHALL have parameter LOST_N, default 3'd4: consecutive invalid frames before the face is declared lost.
REQ-004 SHALL have port module_clk  in  1: clock; all logic SHALL run on its rising edge.
REQ-005 SHALL have port module_rst_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port cam_vsync  in  1: camera frame sync, asynchronous to module_clk.
REQ-007 SHALL have ports face_left, face_right, face_up, face_down  in  12 each: per-frame face box from the face position stage.
REQ-008 SHALL have port roi_ready  in  1: the downstream eye locator accepts the ROI.
REQ-009 SHALL have port roi_valid  out  1: ROI words are valid.
REQ-010 SHALL have ports roi_x0, roi_x1, roi_y0, roi_y1  out  12 each: eye-search window.
REQ-011 SHALL have port face_lost  out  1: no valid face for LOST_N consecutive frames.

Function
REQ-012 SHALL synchronise cam_vsync through two flops and detect the rising edge as vs_r0 & ~vs_r1.
REQ-013 SHALL implement the FSM IDLE->SAMPLE->CHECK->UPDATE->PUBLISH->IDLE; IDLE SHALL leave only on a detected edge or a pending edge.
REQ-014 SAMPLE SHALL latch all four face_* inputs in one cycle; the inputs SHALL be ignored at all other times.
REQ-015 CHECK SHALL mark the frame valid only if all of these hold: right>left; down>up; right-left>=MIN_W; down-up>=MIN_H; right<=639; down<=479. Comparisons SHALL be unsigned 12-bit.
REQ-016 On an invalid frame, CHECK SHALL go to IDLE and SHALL NOT publish; the held ROI SHALL be unchanged; the lost counter SHALL increment, saturating at LOST_N.
REQ-017 On a valid frame, the lost counter SHALL clear and face_lost SHALL deassert in UPDATE.
REQ-018 face_lost SHALL be registered high while the lost counter equals LOST_N.
REQ-019 UPDATE SHALL compute the new window: x0=left, x1=right, y0=up+(h>>2), y1=up+(h>>1), where h=down-up.
REQ-020 In PUBLISH, roi_valid SHALL be high and the roi_* words SHALL stay stable until the cycle in which roi_valid&roi_ready; roi_valid SHALL drop on the next edge.
REQ-021 Latency: with k = the first clock edge sampling cam_vsync high, roi_valid SHALL be high after edge k+4 for a valid frame.
REQ-022 A vsync edge seen outside IDLE SHALL set a pending flag, which IDLE services next; multiple edges SHALL collapse into one pending flag.
REQ-023 roi_valid SHALL never be asserted in any state other than PUBLISH.

Reset
REQ-024 Reset SHALL set: FSM to IDLE; sync flops 0; pending 0; lost counter 0.
REQ-025 Reset SHALL set outputs: roi_valid 0; roi_x0, roi_x1, roi_y0, roi_y1 all 12'd0; face_lost 0.
REQ-026 Reset asserted mid-PUBLISH SHALL drop roi_valid immediately (asynchronous) with no handshake completion.

Configuration
REQ-027 With macro FACE_ROI_SMOOTH_EN defined, UPDATE SHALL output each roi_* as (old+new)>>1, using a 13-bit sum.
REQ-028 With FACE_ROI_SMOOTH_EN defined, the first valid frame after reset, or after face_lost was high, SHALL load directly without averaging.
REQ-029 Without FACE_ROI_SMOOTH_EN, UPDATE SHALL load the new window directly every valid frame.

Verification
REQ-030 Bench SHALL cover: box L=200, R=440, U=100, D=447, roi_ready=1 -> roi_valid high after edge k+4 for 1 cycle; x0=200, x1=440, y0=186, y1=273.
REQ-031 Bench SHALL cover: roi_ready=0 for 10 cycles, then 1 -> roi_valid held 11 cycles with words stable; drops after the handshake.
REQ-032 Bench SHALL cover: 4 frames with R-L=50 -> no roi_valid; face_lost=1 after the 4th CHECK; next valid frame clears face_lost.
REQ-033 Bench SHALL cover: 2 vsync edges during a stalled PUBLISH -> exactly one further publish after release.
REQ-034 Bench SHALL cover, with FACE_ROI_SMOOTH_EN: valid L=200 then valid L=300 -> roi_x0=200, then 250; without the macro -> 200, then 300.
REQ-035 Bench SHALL cover: module_rst_n low during PUBLISH -> all outputs 0 asynchronously; the FSM restarts at IDLE.
